// File: rtl/regfile_pkg.sv
// Shared types, defaults and the address-match helper for the register file.
package regfile_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  // True when an enabled access on addr_b targets addr_a. Callers zero-extend
  // their addresses to 32 bits so one helper serves every depth.
  function automatic logic rf_hit(input logic [31:0] addr_a,
                                  input logic [31:0] addr_b,
                                  input logic        en);
    return en && (addr_a == addr_b);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero-register check, write bypass, init gating.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [AW-1:0]   i_rd_addr,
  input  logic [XLEN-1:0] i_arr_data,
  input  logic            i_busy,
  input  logic            i_wr_commit [NWR],
  input  logic [AW-1:0]   i_wr_addr   [NWR],
  input  logic [XLEN-1:0] i_wr_data   [NWR],
  output logic [XLEN-1:0] o_rd_data
);

  // Array value, overridden by committed writes in ascending port order so the
  // highest-numbered port wins exactly as it does in the array; then gated.
  always_comb begin
    o_rd_data = i_arr_data;
    if (BYPASS != 0) begin
      for (int j = 0; j < NWR; j++) begin
        if (rf_hit(32'(i_rd_addr), 32'(i_wr_addr[j]), i_wr_commit[j])) begin
          o_rd_data = i_wr_data[j];
        end
      end
    end
    if (i_busy || (ZERO_REG != 0 && i_rd_addr == '0)) begin
      o_rd_data = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sequencer.
//
//   state   | meaning
//   RF_INIT | clearing rf[init_ptr] each cycle; writes ignored, reads return 0
//   RF_RUN  | normal operation until the next reset
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN     = RF_XLEN,
  parameter int  NREGS    = RF_NREGS,
  parameter int  NRD      = 2,
  parameter int  NWR      = 1,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rd_addr  [NRD],
  output logic [XLEN-1:0] rd_data  [NRD],
  input  logic            wr_en    [NWR],
  input  logic [AW-1:0]   wr_addr  [NWR],
  input  logic [XLEN-1:0] wr_data  [NWR],
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            init_busy
);

  // One extra pointer bit keeps the terminal index distinct from the wrap to 0.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

  logic [XLEN-1:0] r_rf [NREGS];
  rf_state_t       r_state;
  rf_state_t       w_state_nxt;
  logic [AW:0]     r_init_ptr;
  logic [AW:0]     w_init_ptr_nxt;
  logic            w_busy;
  logic            w_commit [NWR];

  // State and clear-pointer register; reset restarts the full clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RF_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  // Next state: step the pointer through every index, leave after the last.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    if (r_state == RF_INIT) begin
      w_init_ptr_nxt = r_init_ptr + (AW+1)'(1);
      if (r_init_ptr == LAST_IDX) begin
        w_state_nxt = RF_RUN;
      end
    end
  end

  // Busy covers the reset cycle itself so writes presented then are dropped.
  assign w_busy    = reset || (r_state == RF_INIT);
  assign init_busy = w_busy;

  // A write commits only in run, outside reset, and not to a hardwired x0.
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      w_commit[j] = wr_en[j] && !w_busy && !(ZERO_REG != 0 && wr_addr[j] == '0);
    end
  end

  // Storage: sequencer clear during init, else writes with last port winning.
  always_ff @(posedge clk) begin
    if (!reset && r_state == RF_INIT) begin
      r_rf[r_init_ptr[AW-1:0]] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_commit[j]) begin
          r_rf[wr_addr[j]] <= wr_data[j];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rd_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .i_rd_addr   (rd_addr[i]),
      .i_arr_data  (r_rf[rd_addr[i]]),
      .i_busy      (w_busy),
      .i_wr_commit (w_commit),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .o_rd_data   (rd_data[i])
    );
  end

  // Debug read straight from the array, never bypassed.
  always_comb begin
    dbg_data = r_rf[dbg_addr];
    if (w_busy || (ZERO_REG != 0 && dbg_addr == '0)) begin
      dbg_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three configurations sharing clock and reset.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // A: 32x32, NRD=2, NWR=2, ZERO_REG=1, BYPASS=1
  logic [4:0]  a_ra [2];
  logic [31:0] a_rd [2];
  logic        a_we [2];
  logic [4:0]  a_wa [2];
  logic [31:0] a_wd [2];
  logic [4:0]  a_dbga;
  logic [31:0] a_dbg;
  logic        a_busy;

  // B: 32x32, NRD=2, NWR=1, ZERO_REG=0, BYPASS=0
  logic [4:0]  b_ra [2];
  logic [31:0] b_rd [2];
  logic        b_we [1];
  logic [4:0]  b_wa [1];
  logic [31:0] b_wd [1];
  logic [4:0]  b_dbga;
  logic [31:0] b_dbg;
  logic        b_busy;

  // C: 64x64, NRD=3, NWR=1, defaults otherwise
  logic [5:0]  c_ra [3];
  logic [63:0] c_rd [3];
  logic        c_we [1];
  logic [5:0]  c_wa [1];
  logic [63:0] c_wd [1];
  logic [5:0]  c_dbga;
  logic [63:0] c_dbg;
  logic        c_busy;

  regfile_mp #(.NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .rd_addr(a_ra), .rd_data(a_rd), .wr_en(a_we),
    .wr_addr(a_wa), .wr_data(a_wd), .dbg_addr(a_dbga), .dbg_data(a_dbg),
    .init_busy(a_busy));

  regfile_mp #(.NRD(2), .NWR(1), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .rd_addr(b_ra), .rd_data(b_rd), .wr_en(b_we),
    .wr_addr(b_wa), .wr_data(b_wd), .dbg_addr(b_dbga), .dbg_data(b_dbg),
    .init_busy(b_busy));

  regfile_mp #(.XLEN(64), .NREGS(64), .NRD(3), .NWR(1)) u_c (
    .clk(clk), .reset(reset), .rd_addr(c_ra), .rd_data(c_rd), .wr_en(c_we),
    .wr_addr(c_wa), .wr_data(c_wd), .dbg_addr(c_dbga), .dbg_data(c_dbg),
    .init_busy(c_busy));

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  dbga;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] edbg;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    a_we[0] = 1'b0; a_we[1] = 1'b0; a_wa[0] = '0; a_wa[1] = '0;
    a_wd[0] = '0; a_wd[1] = '0; a_ra[0] = '0; a_ra[1] = '0; a_dbga = '0;
    b_we[0] = 1'b0; b_wa[0] = '0; b_wd[0] = '0; b_ra[0] = '0; b_ra[1] = '0; b_dbga = '0;
    c_we[0] = 1'b0; c_wa[0] = '0; c_wd[0] = '0;
    c_ra[0] = '0; c_ra[1] = '0; c_ra[2] = '0; c_dbga = '0;
  endtask

  int na, nb, nc, n;

  initial begin
    // Expectations assume the array is fully cleared and x5 untouched.
    tv[0]  = '{1'b1, 5'd7,  32'hA5A5_0001, 1'b0, 5'd0,  32'h0,    5'd0,  5'd7,  5'd7,  32'h0,      32'hA5A5_0001, 32'h0};
    tv[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    5'd7,  5'd7,  5'd7,  32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001};
    tv[2]  = '{1'b1, 5'd0,  32'h1234_5678, 1'b0, 5'd0,  32'h0,    5'd0,  5'd0,  5'd0,  32'h0,      32'h0,         32'h0};
    tv[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    5'd0,  5'd0,  5'd0,  32'h0,      32'h0,         32'h0};
    tv[4]  = '{1'b1, 5'd9,  32'h1111,      1'b1, 5'd9,  32'h2222, 5'd9,  5'd9,  5'd9,  32'h2222,   32'h2222,      32'h0};
    tv[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    5'd9,  5'd9,  5'd9,  32'h2222,   32'h2222,      32'h2222};
    tv[6]  = '{1'b1, 5'd3,  32'hAAAA,      1'b1, 5'd4,  32'hBBBB, 5'd3,  5'd4,  5'd3,  32'hAAAA,   32'hBBBB,      32'h0};
    tv[7]  = '{1'b1, 5'd3,  32'hCCCC,      1'b1, 5'd0,  32'hDDDD, 5'd0,  5'd3,  5'd3,  32'h0,      32'hCCCC,      32'hAAAA};
    tv[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    5'd3,  5'd4,  5'd4,  32'hCCCC,   32'hBBBB,      32'hBBBB};
    tv[9]  = '{1'b0, 5'd12, 32'h11,        1'b0, 5'd12, 32'h22,   5'd12, 5'd12, 5'd12, 32'h0,      32'h0,         32'h0};
    tv[10] = '{1'b1, 5'd12, 32'h1,         1'b0, 5'd12, 32'h2,    5'd12, 5'd12, 5'd12, 32'h1,      32'h1,         32'h0};
    tv[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    5'd12, 5'd31, 5'd12, 32'h1,      32'h0,         32'h1};

    idle_all();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("busy_in_reset", 64'(a_busy), 64'd1);

    // Init: count cycles until busy drops; a write to x5 is presented meanwhile.
    @(negedge clk);
    reset = 1'b0;
    a_we[0] = 1'b1; a_wa[0] = 5'd5; a_wd[0] = 32'hDEAD_BEEF;
    a_ra[0] = 5'd5; a_dbga = 5'd5;
    #1;
    na = -1; nb = -1; nc = -1;
    for (int k = 0; k < 200; k++) begin
      if (na < 0 && !a_busy) na = k;
      if (nb < 0 && !b_busy) nb = k;
      if (nc < 0 && !c_busy) nc = k;
      if (k == 3) begin
        chk("init_rd_gated", 64'(a_rd[0]), 64'd0);
        chk("init_dbg_gated", 64'(a_dbg), 64'd0);
      end
      if (k == 20) a_we[0] = 1'b0;
      if (na >= 0 && nb >= 0 && nc >= 0) break;
      @(negedge clk);
      #1;
    end
    chk("init_cycles_a", 64'(na), 64'd32);
    chk("init_cycles_b", 64'(nb), 64'd32);
    chk("init_cycles_c", 64'(nc), 64'd64);
    chk("x5_after_init_rd", 64'(a_rd[0]), 64'd0);
    chk("x5_after_init_dbg", 64'(a_dbg), 64'd0);

    // Table-driven run on configuration A.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      a_we[0] = tv[v].we0; a_wa[0] = tv[v].wa0; a_wd[0] = tv[v].wd0;
      a_we[1] = tv[v].we1; a_wa[1] = tv[v].wa1; a_wd[1] = tv[v].wd1;
      a_ra[0] = tv[v].ra0; a_ra[1] = tv[v].ra1; a_dbga = tv[v].dbga;
      #2;
      chk($sformatf("vec%0d_rd0", v), 64'(a_rd[0]), 64'(tv[v].e0));
      chk($sformatf("vec%0d_rd1", v), 64'(a_rd[1]), 64'(tv[v].e1));
      chk($sformatf("vec%0d_dbg", v), 64'(a_dbg), 64'(tv[v].edbg));
    end
    @(negedge clk);
    idle_all();

    // B: writable x0 and no bypass.
    @(negedge clk);
    b_we[0] = 1'b1; b_wa[0] = 5'd0; b_wd[0] = 32'h1234_5678;
    b_ra[0] = 5'd0; b_ra[1] = 5'd7; b_dbga = 5'd7;
    #2;
    chk("b_x0_same_cycle", 64'(b_rd[0]), 64'd0);
    @(negedge clk);
    b_we[0] = 1'b1; b_wa[0] = 5'd7; b_wd[0] = 32'hA5A5_0001;
    #2;
    chk("b_x0_next_cycle", 64'(b_rd[0]), 64'h1234_5678);
    chk("b_x7_no_bypass", 64'(b_rd[1]), 64'd0);
    chk("b_dbg_no_bypass", 64'(b_dbg), 64'd0);
    @(negedge clk);
    b_we[0] = 1'b0;
    #2;
    chk("b_x7_next_cycle", 64'(b_rd[1]), 64'hA5A5_0001);
    chk("b_dbg_next_cycle", 64'(b_dbg), 64'hA5A5_0001);

    // C: wide, deep, three read ports.
    @(negedge clk);
    c_we[0] = 1'b1; c_wa[0] = 6'd63; c_wd[0] = 64'hFFFF_0000_FFFF_0001;
    c_ra[0] = 6'd63; c_ra[1] = 6'd63; c_ra[2] = 6'd63; c_dbga = 6'd63;
    #2;
    for (int p = 0; p < 3; p++)
      chk($sformatf("c_bypass_rd%0d", p), c_rd[p], 64'hFFFF_0000_FFFF_0001);
    chk("c_dbg_no_bypass", c_dbg, 64'd0);
    @(negedge clk);
    c_we[0] = 1'b0;
    #2;
    for (int p = 0; p < 3; p++)
      chk($sformatf("c_array_rd%0d", p), c_rd[p], 64'hFFFF_0000_FFFF_0001);
    chk("c_dbg_array", c_dbg, 64'hFFFF_0000_FFFF_0001);

    // Reset in run, then again at init cycle 10; the clear must restart.
    @(negedge clk);
    reset = 1'b1;
    a_we[0] = 1'b1; a_wa[0] = 5'd20; a_wd[0] = 32'h5555;
    @(negedge clk);
    reset = 1'b0;
    a_we[0] = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("busy_mid_init", 64'(a_busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n = 0;
    while (a_busy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reinit_cycles_a", 64'(n), 64'd32);
    for (int r = 0; r < 32; r++) begin
      a_dbga = 5'(r);
      a_ra[1] = 5'(r);
      #1;
      chk($sformatf("cleared_dbg_x%0d", r), 64'(a_dbg), 64'd0);
      if (r == 3 || r == 9 || r == 12 || r == 20)
        chk($sformatf("cleared_rd_x%0d", r), 64'(a_rd[1]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
